// File: rtl/connect4_pkg.sv
// connect4_pkg
//   Shared definitions for the Connect-Four move sequencer:
//   - default board geometry (columns, rows)
//   - sequencer FSM state encoding
//   - winner codes reported on the winner output
//   - helper that maps the player who just moved to a winner code
package connect4_pkg;

    localparam int DEF_NUM_COLS = 7;
    localparam int DEF_NUM_ROWS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Player 0 (P1) maps to 01, player 1 (P2) maps to 10.
    function automatic logic [1:0] winner_code(input logic player);
        return player ? WIN_P2 : WIN_P1;
    endfunction

endpackage

// File: rtl/move_sequencer_rise_detect.sv
// rise_detect
//   Registered rising-edge detector for an already-synchronised level.
//   Ports:
//     clk    in   clock
//     rst    in   asynchronous active-high reset (clears the previous sample)
//     level  in   synchronised level input
//     rise   out  high while level is 1 and the previous-cycle sample was 0
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer
//   Connect-Four move sequencer. Accepts drop requests for a column, writes
//   the piece into board storage, asks an external win checker to evaluate
//   the move and then hands the turn to the other player or ends the game.
//   Ports:
//     CLOCK_50   in   sole clock, rising edge
//     reset      in   asynchronous active-high reset
//     col_sel    in   selected column (legal range 0..NUM_COLS-1)
//     drop_btn   in   synchronised level; a rising edge requests a drop
//     new_game   in   synchronous restart, overrides everything else
//     chk_done   in   one-cycle pulse from the win checker
//     chk_win    in   win checker result, valid with chk_done
//     wr_en      out  one-cycle board write strobe
//     wr_col     out  write column, valid with wr_en
//     wr_row     out  write row (height before the drop), valid with wr_en
//     wr_player  out  owner of the written piece, valid with wr_en
//     board_clr  out  one-cycle board-storage clear pulse
//     chk_start  out  one-cycle win-check start pulse
//     cur_player out  player to move (0 = P1, 1 = P2)
//     busy       out  high in WRITE and CHECK
//     illegal    out  one-cycle pulse after a rejected drop
//     game_over  out  high while in OVER
//     winner     out  00 none, 01 P1, 10 P2, 11 draw
//     state_dbg  out  current FSM state encoding (observation only)
//
//   Checker protocol: chk_start pulses on the first CHECK cycle; the checker
//   answers with a single chk_done pulse (chk_win qualified by it) at any
//   later point, including the same cycle chk_start is high. chk_done seen
//   in any state other than CHECK carries no meaning and is dropped.
module move_sequencer
    import connect4_pkg::*;
#(
    parameter int NUM_COLS = DEF_NUM_COLS,
    parameter int NUM_ROWS = DEF_NUM_ROWS
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] col_sel,
    input  logic       drop_btn,
    input  logic       new_game,
    input  logic       chk_done,
    input  logic       chk_win,
    output logic       wr_en,
    output logic [2:0] wr_col,
    output logic [2:0] wr_row,
    output logic       wr_player,
    output logic       board_clr,
    output logic       chk_start,
    output logic       cur_player,
    output logic       busy,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [1:0] state_dbg
);

    localparam int HW    = $clog2(NUM_ROWS + 1);
    localparam int CELLS = NUM_COLS * NUM_ROWS;
    localparam int MW    = $clog2(CELLS + 1);

    state_t          state;
    state_t          state_nxt;
    logic            drop_req;
    logic [HW-1:0]   height [NUM_COLS];
    logic [MW-1:0]   move_cnt;
    logic [2:0]      col_q;
    logic            player_q;
    logic [1:0]      winner_q;
    logic            check_entry;
    logic            illegal_q;
    logic            board_clr_q;

    logic [HW-1:0]   sel_height;
    logic [HW-1:0]   wr_height;
    logic            col_in_range;
    logic            drop_ok;
    logic            board_full;

    rise_detect u_rise_detect (
        .clk   (CLOCK_50),
        .rst   (reset),
        .level (drop_btn),
        .rise  (drop_req)
    );

    // Height lookups are plain muxes over the per-column counters.
    always_comb begin
        sel_height = '0;
        wr_height  = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (int'(col_sel) == c) sel_height = height[c];
            if (int'(col_q) == c)   wr_height  = height[c];
        end
    end

    always_comb begin
        col_in_range = int'(col_sel) < NUM_COLS;
        // sel_height is 0 when out of range, so the range test must gate it.
        drop_ok      = drop_req && col_in_range && (int'(sel_height) < NUM_ROWS);
        // The move counter is already bumped by WRITE when CHECK inspects it.
        board_full   = int'(move_cnt) == CELLS;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (new_game) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (drop_ok) state_nxt = ST_WRITE;
                ST_WRITE: state_nxt = ST_CHECK;
                ST_CHECK: if (chk_done) state_nxt = (chk_win || board_full) ? ST_OVER : ST_IDLE;
                ST_OVER:  state_nxt = ST_OVER;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        wr_en      = (state == ST_WRITE);
        wr_col     = col_q;
        wr_row     = 3'(wr_height);
        wr_player  = player_q;
        chk_start  = (state == ST_CHECK) && check_entry;
        busy       = (state == ST_WRITE) || (state == ST_CHECK);
        game_over  = (state == ST_OVER);
        winner     = winner_q;
        cur_player = player_q;
        illegal    = illegal_q;
        board_clr  = board_clr_q;
        state_dbg  = state;
    end

    // ---------------- Game bookkeeping ----------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_COLS; c++) height[c] <= '0;
            move_cnt    <= '0;
            col_q       <= '0;
            player_q    <= 1'b0;
            winner_q    <= WIN_NONE;
            check_entry <= 1'b0;
            illegal_q   <= 1'b0;
            board_clr_q <= 1'b0;
        end else begin
            illegal_q   <= 1'b0;
            board_clr_q <= 1'b0;
            check_entry <= 1'b0;
            if (new_game) begin
                for (int c = 0; c < NUM_COLS; c++) height[c] <= '0;
                move_cnt    <= '0;
                player_q    <= 1'b0;
                winner_q    <= WIN_NONE;
                board_clr_q <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (drop_ok) begin
                            col_q <= col_sel;
                        end else if (drop_req) begin
                            illegal_q <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        for (int c = 0; c < NUM_COLS; c++) begin
                            if (int'(col_q) == c) height[c] <= height[c] + 1'b1;
                        end
                        move_cnt    <= move_cnt + 1'b1;
                        check_entry <= 1'b1;
                    end
                    ST_CHECK: begin
                        if (chk_done) begin
                            if (chk_win) begin
                                winner_q <= winner_code(player_q);
                            end else if (board_full) begin
                                winner_q <= WIN_DRAW;
                            end else begin
                                player_q <= ~player_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
//   Bench for move_sequencer: drives drops, checker responses and restarts,
//   predicts board writes with a small game model and compares outcomes.
module tb_move_sequencer;
    import connect4_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0] col_sel;
    logic       drop_btn, new_game, chk_done, chk_win;
    logic       wr_en, wr_player, board_clr, chk_start, cur_player;
    logic       busy, illegal, game_over;
    logic [2:0] wr_col, wr_row;
    logic [1:0] winner, state_dbg;

    move_sequencer dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .col_sel    (col_sel),
        .drop_btn   (drop_btn),
        .new_game   (new_game),
        .chk_done   (chk_done),
        .chk_win    (chk_win),
        .wr_en      (wr_en),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_player  (wr_player),
        .board_clr  (board_clr),
        .chk_start  (chk_start),
        .cur_player (cur_player),
        .busy       (busy),
        .illegal    (illegal),
        .game_over  (game_over),
        .winner     (winner),
        .state_dbg  (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- game model ----------------
    int        mh [7];
    int        mmoves;
    bit        mplayer;
    bit        mover;
    logic [1:0] mwin;

    task automatic model_clear();
        for (int c = 0; c < 7; c++) mh[c] = 0;
        mmoves  = 0;
        mplayer = 1'b0;
        mover   = 1'b0;
        mwin    = WIN_NONE;
    endtask

    // ---------------- scoreboard: {col, row, player} per write ----------------
    logic [6:0] exp_q[$];
    int         wr_seen = 0;

    always @(negedge clk) begin
        if (reset === 1'b0 && wr_en === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {wr_col, wr_row, wr_player}, 7'h7f);
            end else begin
                check("wr_txn", {wr_col, wr_row, wr_player}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_status(input string tag);
        check({tag, "_player"}, cur_player, mplayer);
        check({tag, "_over"},   game_over,  mover);
        check({tag, "_winner"}, winner,     mwin);
        check({tag, "_state"},  state_dbg,  mover ? ST_OVER : ST_IDLE);
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check("ng_clr", board_clr, 1'b1);
        check_status("ng");
        @(negedge clk);
        check("ng_clr_pulse", board_clr, 1'b0);
    endtask

    task automatic drop(input int col, input bit win);
        bit legal;
        legal = 1'b0;
        if (col < 7) legal = (mh[col] < 6);
        @(negedge clk);
        col_sel  = col[2:0];
        drop_btn = 1'b1;
        if (!mover && legal) exp_q.push_back({col[2:0], 3'(mh[col]), mplayer});
        @(negedge clk);
        drop_btn = 1'b0;
        if (mover) begin
            check("ovr_no_ill", illegal, 1'b0);
            check("ovr_state", state_dbg, ST_OVER);
            @(negedge clk);
            return;
        end
        if (!legal) begin
            check("ill_pulse", illegal, 1'b1);
            check("ill_state", state_dbg, ST_IDLE);
            @(negedge clk);
            check("ill_pulse_end", illegal, 1'b0);
            check_status("ill");
            return;
        end
        check("w_state", state_dbg, ST_WRITE);
        check("w_busy", busy, 1'b1);
        mh[col]++;
        mmoves++;
        @(negedge clk);
        check("chk_start", chk_start, 1'b1);
        check("c_state", state_dbg, ST_CHECK);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("chk_start_once", chk_start, 1'b0);
        end
        chk_done = 1'b1;
        chk_win  = win;
        @(negedge clk);
        chk_done = 1'b0;
        chk_win  = 1'b0;
        if (win) begin
            mover = 1'b1;
            mwin  = mplayer ? WIN_P2 : WIN_P1;
        end else if (mmoves == 42) begin
            mover = 1'b1;
            mwin  = WIN_DRAW;
        end else begin
            mplayer = ~mplayer;
        end
        check_status("done");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr_before;
        reset = 1'b1; col_sel = '0; drop_btn = 1'b0; new_game = 1'b0;
        chk_done = 1'b0; chk_win = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_clr", board_clr, 1'b0);
        check("rst_start", chk_start, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_status("rst");
        reset = 1'b0;

        // First move, then P2 wins.
        drop(3, 1'b0);
        drop(4, 1'b1);
        drop(2, 1'b0);                // discarded in OVER
        do_new_game();

        // chk_done outside CHECK has no effect.
        @(negedge clk);
        chk_done = 1'b1; chk_win = 1'b1;
        @(negedge clk);
        chk_done = 1'b0; chk_win = 1'b0;
        check_status("stray_done");

        // Column fill then overflow.
        for (int i = 0; i < 6; i++) drop(0, 1'b0);
        drop(0, 1'b0);
        drop(7, 1'b0);
        do_new_game();

        // P1 wins, further drops ignored, restart.
        drop(5, 1'b1);
        drop(5, 1'b0);
        drop(1, 1'b0);
        do_new_game();

        // Fill the whole board; an out-of-range drop mid-way must not count.
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                drop(c, 1'b0);
                if (c == 3 && r == 2) drop(7, 1'b0);
            end
        end
        check("draw_winner", winner, WIN_DRAW);
        do_new_game();

        // Held button gives one drop; new_game beats a simultaneous winning chk_done.
        wr_before = wr_seen;
        @(negedge clk);
        col_sel  = 3'd6;
        drop_btn = 1'b1;
        exp_q.push_back({3'd6, 3'd0, 1'b0});
        repeat (10) @(negedge clk);
        drop_btn = 1'b0;
        check("held_one_wr", wr_seen - wr_before, 1);
        check("held_state", state_dbg, ST_CHECK);
        new_game = 1'b1; chk_done = 1'b1; chk_win = 1'b1;
        @(negedge clk);
        new_game = 1'b0; chk_done = 1'b0; chk_win = 1'b0;
        model_clear();
        check("ng_win_clr", board_clr, 1'b1);
        check_status("ng_win");

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter NUM_COLS, default 7, board columns.
REQ-002 Parameter NUM_ROWS, default 6, board rows; row 0 is the bottom row.
REQ-003 CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 col_sel  in  3  selected column (valid 0..NUM_COLS-1).
REQ-006 drop_btn  in  1  synchronized, active-high level; rising edge = drop request.
REQ-007 new_game  in  1  synchronous, active-high restart.
REQ-008 chk_done  in  1  win checker finished, one-cycle pulse.
REQ-009 chk_win  in  1  win checker result, valid with chk_done.
REQ-010 wr_en  out  1  one-cycle board write strobe.
REQ-011 wr_col  out  3 / wr_row  out  3 / wr_player  out  1  write address and piece owner, valid with wr_en.
REQ-012 board_clr  out  1  one-cycle board-storage clear pulse.
REQ-013 chk_start  out  1  one-cycle win-check start pulse.
REQ-014 cur_player  out  1  player to move (0 = P1, 1 = P2).
REQ-015 busy  out  1  high in every state except IDLE and OVER.
REQ-016 illegal  out  1  one-cycle pulse on a rejected drop.
REQ-017 game_over  out  1 / winner  out  2  (00 none, 01 P1, 10 P2, 11 draw).

Function
REQ-018 FSM states: IDLE, WRITE, CHECK, OVER.
REQ-019 Per-column height counters (0..NUM_ROWS) and a move counter (0..NUM_COLS*NUM_ROWS) held internally.
REQ-020 Drop request = drop_btn high this cycle, low last cycle (registered previous value).
REQ-021 IDLE + drop request + col_sel < NUM_COLS + height[col_sel] < NUM_ROWS: latch col_sel, go to WRITE next cycle.
REQ-022 IDLE + drop request with col_sel >= NUM_COLS or column full: illegal pulses next cycle, stay IDLE, no other state change.
REQ-023 WRITE (exactly one cycle): wr_en=1, wr_col=latched column, wr_row=height[col] before increment, wr_player=cur_player; increment height[col] and move counter; go to CHECK.
REQ-024 CHECK entry cycle: chk_start=1 for one cycle; remain in CHECK until chk_done.
REQ-025 chk_done with chk_win=1: go to OVER, game_over=1, winner = cur_player+1.
REQ-026 chk_done with chk_win=0 and move counter = NUM_COLS*NUM_ROWS: go to OVER, winner=11.
REQ-027 chk_done otherwise: toggle cur_player, return to IDLE.
REQ-028 Drop requests in WRITE, CHECK, OVER are discarded, not queued, and do not pulse illegal.
REQ-029 chk_done outside CHECK is ignored.
REQ-030 new_game (any state): next cycle IDLE, heights/move counter cleared, cur_player=0, game_over=0, winner=00, board_clr=1 for one cycle; it overrides a simultaneous drop request or chk_done.
REQ-031 Latency: drop edge at cycle N -> wr_en at N+1 -> chk_start at N+2.

Reset
REQ-032 On reset: state IDLE, all heights and move counter 0, cur_player=0, previous drop_btn sample=0, all pulse outputs 0, game_over=0, winner=00, board_clr=0.
REQ-033 Reset mid-CHECK abandons the check; a later chk_done is ignored per REQ-029.

Structure
REQ-034 Shared package/include connect4_pkg holds NUM_COLS, NUM_ROWS defaults, state encodings and winner codes.
REQ-035 One sub-module: rise_detect (registered rising-edge detector for drop_btn).
REQ-036 Column heights implemented as NUM_COLS independent counters; no board scan.

Verification
REQ-037 Reset, drop col 3 -> wr_en with wr_col=3, wr_row=0, wr_player=0; chk_start next cycle; chk_done/chk_win=0 -> cur_player=1.
REQ-038 Six drops in col 0 (chk_win=0 each) then a seventh -> illegal pulse, no wr_en, cur_player unchanged.
REQ-039 col_sel=7 drop -> illegal pulse, state IDLE, move counter unchanged.
REQ-040 P1 drop with chk_done/chk_win=1 -> game_over=1, winner=01; further drops ignored; new_game -> board_clr pulse, winner=00, cur_player=0.
REQ-041 Fill all 42 cells with chk_win=0 -> after the 42nd check winner=11, game_over=1.
REQ-042 drop_btn held high 10 cycles -> exactly one wr_en; new_game asserted same cycle as chk_done(win) -> IDLE, game_over=0.
